// File: rtl/wb_stage_pkg.sv
// Shared constants for the RV64 write-back stage: datapath sizing and load funct3 encodings.
// Optional build macro: WB_RETIRE_CNT_EN (adds the retire_cnt output to wb_stage).
package wb_stage_pkg;

  localparam int XLEN = 64;
  localparam int NREG = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_stage_load_align.sv
// Combinational load-data aligner: selects the byte/half/word lane addressed by addr_lo_i
// and sign- or zero-extends it; misaligned low address bits are simply dropped.
module load_align
  import wb_stage_pkg::*;
(
  input  logic [XLEN-1:0] res_i,
  input  logic [2:0]      funct3_i,
  input  logic [2:0]      addr_lo_i,
  input  logic            is_load_i,
  output logic [XLEN-1:0] data_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] word_lane;

  // Lane offsets are rounded down to the access size, so misalignment never traps here.
  assign byte_lane = res_i[{addr_lo_i, 3'b000} +: 8];
  assign half_lane = res_i[{addr_lo_i[2:1], 4'b0000} +: 16];
  assign word_lane = res_i[{addr_lo_i[2], 5'b00000} +: 32];

  always_comb begin
    data_o = res_i;
    if (is_load_i) begin
      case (funct3_i)
        F3_LB:   data_o = {{(XLEN-8){byte_lane[7]}}, byte_lane};
        F3_LH:   data_o = {{(XLEN-16){half_lane[15]}}, half_lane};
        F3_LW:   data_o = {{(XLEN-32){word_lane[31]}}, word_lane};
        F3_LBU:  data_o = {{(XLEN-8){1'b0}}, byte_lane};
        F3_LHU:  data_o = {{(XLEN-16){1'b0}}, half_lane};
        F3_LWU:  data_o = {{(XLEN-32){1'b0}}, word_lane};
        default: data_o = res_i;
      endcase
    end
  end

endmodule

// File: rtl/wb_stage.sv
// RV64 write-back stage: captures the memory-stage result, commits it to a 32x64 register file
// one edge later, and serves two write-first bypassed read ports. Optional macro: WB_RETIRE_CNT_EN.
module wb_stage
  import wb_stage_pkg::*;
(
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            stall,
  input  logic            mem_write_back_en,
  input  logic [4:0]      rd_i,
  input  logic [XLEN-1:0] res,
  input  logic            is_load,
  input  logic [2:0]      load_funct3,
  input  logic [2:0]      addr_lo,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [63:0]     retire_cnt
`endif
);

  logic [XLEN-1:0] aligned;
  logic            valid_q, valid_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] data_q, data_d;
  logic [XLEN-1:0] rf_q [NREG];

  load_align u_align (
    .res_i     (res),
    .funct3_i  (load_funct3),
    .addr_lo_i (addr_lo),
    .is_load_i (is_load),
    .data_o    (aligned)
  );

  // A write to x0 is dropped at capture so the file entry 0 can never change.
  always_comb begin
    valid_d = valid_q;
    rd_d    = rd_q;
    data_d  = data_q;
    if (!stall) begin
      valid_d = mem_write_back_en && (rd_i != REG_ZERO);
      rd_d    = rd_i;
      data_d  = aligned;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      valid_q <= 1'b0;
      rd_q    <= REG_ZERO;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
    end
  end

  // Commit repeats every edge while a stalled write is pending; rewriting the same value is harmless.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= '0;
      end
    end else if (valid_q) begin
      rf_q[rd_q] <= data_q;
    end
  end

  always_comb begin
    rs1_data = rf_q[rs1_addr];
    if (rs1_addr == REG_ZERO) begin
      rs1_data = '0;
    end else if (valid_q && (rd_q == rs1_addr)) begin
      rs1_data = data_q;
    end
  end

  always_comb begin
    rs2_data = rf_q[rs2_addr];
    if (rs2_addr == REG_ZERO) begin
      rs2_data = '0;
    end else if (valid_q && (rd_q == rs2_addr)) begin
      rs2_data = data_q;
    end
  end

  assign wb_valid = valid_q;
  assign wb_rd    = rd_q;
  assign wb_data  = data_q;

`ifdef WB_RETIRE_CNT_EN
  // Counts every accepted write-back request, including those aimed at x0.
  logic [63:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!stall && mem_write_back_en) begin
      cnt_d = cnt_q + 64'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign retire_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: alignment vector table, directed corner sequences and
// randomized traffic against an architectural model of the stage and register file.
module tb_wb_stage;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        stall = 1'b0;
  logic        mem_write_back_en = 1'b0;
  logic [4:0]  rd_i = '0;
  logic [63:0] res = '0;
  logic        is_load = 1'b0;
  logic [2:0]  load_funct3 = '0;
  logic [2:0]  addr_lo = '0;
  logic [4:0]  rs1_addr = '0;
  logic [4:0]  rs2_addr = '0;
  logic [63:0] rs1_data, rs2_data, wb_data;
  logic        wb_valid;
  logic [4:0]  wb_rd;
`ifdef WB_RETIRE_CNT_EN
  logic [63:0] retire_cnt;
`endif

  wb_stage dut (
    .CLK               (CLK),
    .RST_N             (RST_N),
    .stall             (stall),
    .mem_write_back_en (mem_write_back_en),
    .rd_i              (rd_i),
    .res               (res),
    .is_load           (is_load),
    .load_funct3       (load_funct3),
    .addr_lo           (addr_lo),
    .rs1_addr          (rs1_addr),
    .rs2_addr          (rs2_addr),
    .rs1_data          (rs1_data),
    .rs2_data          (rs2_data),
    .wb_valid          (wb_valid),
    .wb_rd             (wb_rd),
    .wb_data           (wb_data)
`ifdef WB_RETIRE_CNT_EN
    ,
    .retire_cnt        (retire_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int passed = 0;

  // Architectural model: committed file plus one pending write.
  logic [63:0] m_rf [32];
  logic        m_pv;
  logic [4:0]  m_prd;
  logic [63:0] m_pdata;
  logic [63:0] m_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [63:0] ref_align(input logic [63:0] r, input logic [2:0] f3,
                                            input logic [2:0] off, input logic ld);
    int size, lane, bits;
    logic [63:0] v, mask;
    if (!ld || f3[1:0] == 2'b11) return r;
    size = 1 << f3[1:0];
    lane = (int'(off) / size) * size;
    bits = 8 * size;
    mask = (64'd1 << bits) - 64'd1;
    v = (r >> (8 * lane)) & mask;
    if (!f3[2] && v[bits-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [63:0] ref_read(input logic [4:0] a);
    if (a == 5'd0) return 64'd0;
    if (m_pv && m_prd == a) return m_pdata;
    return m_rf[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = 64'd0;
    m_pv = 1'b0; m_prd = 5'd0; m_pdata = 64'd0; m_cnt = 64'd0;
  endtask

  task automatic tick();
    @(posedge CLK);
    if (RST_N) begin
      if (m_pv) m_rf[m_prd] = m_pdata;
      if (!stall) begin
        if (mem_write_back_en) m_cnt = m_cnt + 64'd1;
        m_pv    = mem_write_back_en && rd_i != 5'd0;
        m_prd   = rd_i;
        m_pdata = ref_align(res, load_funct3, addr_lo, is_load);
      end
    end
    #1;
  endtask

  task automatic drive(input logic en, input logic [4:0] rd, input logic [63:0] r,
                       input logic ld, input logic [2:0] f3, input logic [2:0] off);
    mem_write_back_en = en; rd_i = rd; res = r; is_load = ld; load_funct3 = f3; addr_lo = off;
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".wb_valid"}, {63'd0, wb_valid}, {63'd0, m_pv});
    chk({tag, ".wb_rd"}, {59'd0, wb_rd}, {59'd0, m_prd});
    chk({tag, ".wb_data"}, wb_data, m_pdata);
    chk({tag, ".rs1"}, rs1_data, ref_read(rs1_addr));
    chk({tag, ".rs2"}, rs2_data, ref_read(rs2_addr));
`ifdef WB_RETIRE_CNT_EN
    chk({tag, ".retire_cnt"}, retire_cnt, m_cnt);
`endif
  endtask

  typedef struct {
    logic [63:0] r;
    logic [2:0]  f3;
    logic [2:0]  off;
    logic        ld;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs [14];
  localparam logic [63:0] PAT = 64'h8877_6655_4433_2211;

  initial begin
    vecs[0]  = '{PAT, 3'b000, 3'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FF88};
    vecs[1]  = '{PAT, 3'b100, 3'd7, 1'b1, 64'h0000_0000_0000_0088};
    vecs[2]  = '{PAT, 3'b010, 3'd4, 1'b1, 64'hFFFF_FFFF_8877_6655};
    vecs[3]  = '{PAT, 3'b110, 3'd4, 1'b1, 64'h0000_0000_8877_6655};
    vecs[4]  = '{PAT, 3'b000, 3'd0, 1'b1, 64'h0000_0000_0000_0011};
    vecs[5]  = '{PAT, 3'b001, 3'd6, 1'b1, 64'hFFFF_FFFF_FFFF_8877};
    vecs[6]  = '{PAT, 3'b001, 3'd7, 1'b1, 64'hFFFF_FFFF_FFFF_8877};
    vecs[7]  = '{PAT, 3'b101, 3'd2, 1'b1, 64'h0000_0000_0000_4433};
    vecs[8]  = '{PAT, 3'b010, 3'd1, 1'b1, 64'h0000_0000_4433_2211};
    vecs[9]  = '{PAT, 3'b011, 3'd5, 1'b1, PAT};
    vecs[10] = '{PAT, 3'b111, 3'd3, 1'b1, PAT};
    vecs[11] = '{PAT, 3'b000, 3'd7, 1'b0, PAT};
    vecs[12] = '{PAT, 3'b100, 3'd3, 1'b1, 64'h0000_0000_0000_0044};
    vecs[13] = '{PAT, 3'b000, 3'd5, 1'b1, 64'h0000_0000_0000_0066};

    model_reset();

    // Reset: everything reads zero, both while held and after release.
    #3;
    chk("rst_held.wb_valid", {63'd0, wb_valid}, 64'd0);
    repeat (2) tick();
    #2 RST_N = 1'b1;
    tick();
    chk("rst.wb_valid", {63'd0, wb_valid}, 64'd0);
    chk("rst.wb_rd", {59'd0, wb_rd}, 64'd0);
    chk("rst.wb_data", wb_data, 64'd0);
    for (int i = 1; i < 32; i++) begin
      rs1_addr = 5'(i); #1;
      chk($sformatf("rst.x%0d", i), rs1_data, 64'd0);
    end
    $display("txn reset: regfile cleared");

    // Alignment table.
    for (int i = 0; i < 14; i++) begin
      drive(1'b1, 5'd1, vecs[i].r, vecs[i].ld, vecs[i].f3, vecs[i].off);
      tick();
      chk($sformatf("align[%0d]", i), wb_data, vecs[i].exp);
      $display("txn align[%0d]: f3=%b off=%0d ld=%0b -> %h", i, vecs[i].f3, vecs[i].off, vecs[i].ld, wb_data);
    end

    // Bypass before commit, file after commit.
    drive(1'b1, 5'd5, 64'h1234, 1'b0, 3'b000, 3'd0);
    tick();
    drive(1'b0, 5'd0, 64'd0, 1'b0, 3'b000, 3'd0);
    rs1_addr = 5'd5; #1;
    chk("bypass.pre", rs1_data, 64'h1234);
    tick();
    chk("bypass.valid_after", {63'd0, wb_valid}, 64'd0);
    chk("bypass.post", rs1_data, 64'h1234);
    $display("txn bypass: x5=%h", rs1_data);

    // x0 guard.
    drive(1'b1, 5'd0, 64'hDEAD, 1'b0, 3'b000, 3'd0);
    rs2_addr = 5'd0;
    tick();
    chk("x0.wb_valid", {63'd0, wb_valid}, 64'd0);
    chk("x0.rs2", rs2_data, 64'd0);
    drive(1'b0, 5'd0, 64'd0, 1'b0, 3'b000, 3'd0);
    tick();
    chk("x0.after", rs2_data, 64'd0);
    $display("txn x0: write dropped");

    // Stall holds pending write A while inputs present B.
    drive(1'b1, 5'd3, 64'hAAAA_0001, 1'b0, 3'b000, 3'd0);
    tick();
    stall = 1'b1;
    drive(1'b1, 5'd3, 64'hBBBB_0002, 1'b0, 3'b000, 3'd0);
    rs1_addr = 5'd3;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("stall.hold%0d", i), wb_data, 64'hAAAA_0001);
      chk($sformatf("stall.rs1_%0d", i), rs1_data, 64'hAAAA_0001);
    end
    stall = 1'b0;
    tick();
    chk("stall.capB", wb_data, 64'hBBBB_0002);
    drive(1'b0, 5'd0, 64'd0, 1'b0, 3'b000, 3'd0);
    tick();
    chk("stall.x3_file", rs1_data, 64'hBBBB_0002);
    chk("stall.valid", {63'd0, wb_valid}, 64'd0);
    $display("txn stall: x3=%h", rs1_data);

    // Back-to-back writes to the same register.
    drive(1'b1, 5'd7, 64'h7777_0001, 1'b0, 3'b000, 3'd0);
    tick();
    drive(1'b1, 5'd7, 64'h7777_0002, 1'b0, 3'b000, 3'd0);
    tick();
    drive(1'b0, 5'd0, 64'd0, 1'b0, 3'b000, 3'd0);
    tick();
    rs2_addr = 5'd7; #1;
    chk("b2b.x7", rs2_data, 64'h7777_0002);
    $display("txn b2b: x7=%h", rs2_data);

    // Reset during a stalled pending write discards it.
    drive(1'b1, 5'd9, 64'h9999, 1'b0, 3'b000, 3'd0);
    tick();
    stall = 1'b1;
    rs1_addr = 5'd9;
    #2 RST_N = 1'b0;
    model_reset();
    #1;
    chk("rstmid.wb_valid", {63'd0, wb_valid}, 64'd0);
    chk("rstmid.x9", rs1_data, 64'd0);
    chk("rstmid.x7", rs2_data, 64'd0);
    tick();
    #2 RST_N = 1'b1;
    stall = 1'b0;
    drive(1'b0, 5'd0, 64'd0, 1'b0, 3'b000, 3'd0);
    tick();
    chk("rstmid.x9_after", rs1_data, 64'd0);
    $display("txn reset_mid_stall: pending write discarded");

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)),
            {$urandom, $urandom}, 1'($urandom), 3'($urandom), 3'($urandom));
      if ($urandom_range(0, 7) == 0) rd_i = 5'd0;
      stall = ($urandom_range(0, 3) == 0);
      rs1_addr = 5'($urandom_range(0, 31));
      rs2_addr = ($urandom_range(0, 2) == 0) ? rd_i : 5'($urandom_range(0, 31));
      tick();
      chk_state($sformatf("rnd[%0d]", i));
      $display("txn rnd[%0d]: en=%0b rd=%0d stall=%0b ld=%0b f3=%b off=%0d wb=%0b/%0d/%h",
               i, mem_write_back_en, rd_i, stall, is_load, load_funct3, addr_lo,
               wb_valid, wb_rd, wb_data);
    end

    stall = 1'b0;
    drive(1'b0, 5'd0, 64'd0, 1'b0, 3'b000, 3'd0);
    tick();
    for (int i = 1; i < 32; i++) begin
      rs1_addr = 5'(i); #1;
      chk($sformatf("final.x%0d", i), rs1_data, m_rf[i]);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
